// File: rtl/lstm_pkg.sv
// Shared definitions for the LSTM forward sequencer and its datapath peers.
package lstm_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ZERO,
      ST_MAC,
      ST_DRAIN,
      ST_WRITE,
      ST_DONE
   } state_e;

   // Accumulate beats per cell: every input feature, every recurrent h, plus the bias.
   function automatic int unsigned mac_len(input int unsigned num_input,
                                           input int unsigned num_cell);
      return num_input + num_cell + 1;
   endfunction

   // H/C slot address; slot 0..num_cell-1 holds the t=-1 state, so timestep t lives one row up.
   function automatic int unsigned hc_slot_addr(input int unsigned t,
                                                input int unsigned k,
                                                input int unsigned num_cell);
      return (t + 1) * num_cell + k;
   endfunction

endpackage

// File: rtl/cnt_tc.sv
// Up-counter with enable, synchronous clear and terminal-count flag; wraps to 0 after MAX_VAL.
module cnt_tc #(
   parameter int unsigned WIDTH   = 12,
   parameter int unsigned MAX_VAL = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             clr,
   output logic [WIDTH-1:0] o_cnt,
   output logic             o_tc
);

   logic [WIDTH-1:0] cnt_q;
   logic [WIDTH-1:0] cnt_d;

   assign o_cnt = cnt_q;
   assign o_tc  = (cnt_q == WIDTH'(MAX_VAL));

   // Next count: clear wins over enable; enabled at terminal count wraps to zero.
   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en) begin
         cnt_d = o_tc ? '0 : cnt_q + WIDTH'(1);
      end
   end

   // Count register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/lstm_fwd_ctrl.sv
// LSTM forward-propagation sequencer: zero-fills the t=-1 H/C slot, then for each
// timestep and cell runs the MAC beats, waits out the activation pipeline and writes back.
module lstm_fwd_ctrl
   import lstm_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 12,
   parameter int unsigned TIMESTEP   = 7,
   parameter int unsigned NUM_CELL   = 8,
   parameter int unsigned NUM_INPUT  = 53,
   parameter int unsigned DELAY      = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_start,
   input  logic                  i_hold,
   output logic                  o_busy,
   output logic                  o_done,
   output logic                  o_addr_en,
   output logic                  o_acc_en,
   output logic                  o_clr_acc,
   output logic [ADDR_WIDTH-1:0] o_mac_idx,
   output logic                  o_wr_en,
   output logic                  o_wr_zero,
   output logic [ADDR_WIDTH-1:0] o_wr_addr,
   output logic [ADDR_WIDTH-1:0] o_t,
   output logic [ADDR_WIDTH-1:0] o_k
);

   localparam int unsigned MAC_LEN = mac_len(NUM_INPUT, NUM_CELL);

   state_e state_q;
   state_e state_d;

   logic                  run;
   logic                  cnt_clr;
   logic [ADDR_WIDTH-1:0] j_cnt, d_cnt, k_cnt, t_cnt, z_cnt;
   logic                  j_tc, d_tc, k_tc, t_tc, z_tc;
   logic                  j_en, d_en, k_en, t_en, z_en;

   // Hold freezes everything in the active states; IDLE/DONE never look at it.
   assign run     = !i_hold;
   assign cnt_clr = (state_q == ST_IDLE) || (state_q == ST_DONE);

   // Counter enables: each counter advances only in its own state and only when not held.
   always_comb begin
      z_en = (state_q == ST_ZERO)  && run;
      j_en = (state_q == ST_MAC)   && run;
      d_en = (state_q == ST_DRAIN) && run;
      k_en = (state_q == ST_WRITE) && run;
      // t stays on the last timestep through DONE rather than wrapping.
      t_en = (state_q == ST_WRITE) && run && k_tc && !t_tc;
   end

   cnt_tc #(.WIDTH(ADDR_WIDTH), .MAX_VAL(NUM_CELL - 1)) u_z (
      .clk(clk), .rst_n(rst), .en(z_en), .clr(cnt_clr), .o_cnt(z_cnt), .o_tc(z_tc));
   cnt_tc #(.WIDTH(ADDR_WIDTH), .MAX_VAL(MAC_LEN - 1)) u_j (
      .clk(clk), .rst_n(rst), .en(j_en), .clr(cnt_clr), .o_cnt(j_cnt), .o_tc(j_tc));
   cnt_tc #(.WIDTH(ADDR_WIDTH), .MAX_VAL(DELAY - 1)) u_d (
      .clk(clk), .rst_n(rst), .en(d_en), .clr(cnt_clr), .o_cnt(d_cnt), .o_tc(d_tc));
   cnt_tc #(.WIDTH(ADDR_WIDTH), .MAX_VAL(NUM_CELL - 1)) u_k (
      .clk(clk), .rst_n(rst), .en(k_en), .clr(cnt_clr), .o_cnt(k_cnt), .o_tc(k_tc));
   cnt_tc #(.WIDTH(ADDR_WIDTH), .MAX_VAL(TIMESTEP - 1)) u_t (
      .clk(clk), .rst_n(rst), .en(t_en), .clr(cnt_clr), .o_cnt(t_cnt), .o_tc(t_tc));

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; counters wrap on their own so transitions only watch terminal counts.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:  if (i_start)      state_d = ST_ZERO;
         ST_ZERO:  if (run && z_tc)  state_d = ST_MAC;
         ST_MAC:   if (run && j_tc)  state_d = ST_DRAIN;
         ST_DRAIN: if (run && d_tc)  state_d = ST_WRITE;
         ST_WRITE: if (run)          state_d = (k_tc && t_tc) ? ST_DONE : ST_MAC;
         ST_DONE:                    state_d = ST_IDLE;
         default:                    state_d = ST_IDLE;
      endcase
   end

   // Output decode from registered state/counters; only the strobes see i_hold directly.
   always_comb begin
      o_busy    = (state_q != ST_IDLE);
      o_done    = (state_q == ST_DONE);
      o_addr_en = (state_q == ST_MAC) && run;
      o_acc_en  = (state_q == ST_MAC) && run;
      o_clr_acc = (state_q == ST_MAC) && run && (j_cnt == '0);
      o_mac_idx = j_cnt;
      o_wr_en   = ((state_q == ST_ZERO) || (state_q == ST_WRITE)) && run;
      o_wr_zero = (state_q == ST_ZERO);
      o_wr_addr = '0;
      if (state_q == ST_ZERO) begin
         o_wr_addr = z_cnt;
      end else if (state_q == ST_WRITE) begin
         o_wr_addr = ADDR_WIDTH'(hc_slot_addr(32'(t_cnt), 32'(k_cnt), NUM_CELL));
      end
      o_t = t_cnt;
      o_k = k_cnt;
   end

endmodule

// File: tb/tb_lstm_fwd_ctrl.sv
// Directed bench for lstm_fwd_ctrl: a small-parameter instance carries the scoreboarded
// write sequence, hold, re-start and reset scenarios; a DELAY=4 instance checks the drain
// gap; a default-parameter instance checks full-size totals.
module tb_lstm_fwd_ctrl;

   localparam int unsigned AW = 12;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // ---------------- small instance: T=2, NC=2, NI=3, DELAY=1 (MAC_LEN=6)
   logic s_rst, s_start, s_hold;
   logic s_busy, s_done, s_addr_en, s_acc, s_clr, s_wr_en, s_wr_zero;
   logic [AW-1:0] s_idx, s_wr_addr, s_t, s_k;

   lstm_fwd_ctrl #(.ADDR_WIDTH(AW), .TIMESTEP(2), .NUM_CELL(2), .NUM_INPUT(3), .DELAY(1)) u_small (
      .clk(clk), .rst(s_rst), .i_start(s_start), .i_hold(s_hold),
      .o_busy(s_busy), .o_done(s_done), .o_addr_en(s_addr_en), .o_acc_en(s_acc),
      .o_clr_acc(s_clr), .o_mac_idx(s_idx), .o_wr_en(s_wr_en), .o_wr_zero(s_wr_zero),
      .o_wr_addr(s_wr_addr), .o_t(s_t), .o_k(s_k));

   logic [54:0] s_all;
   assign s_all = {s_busy, s_done, s_addr_en, s_acc, s_clr, s_idx, s_wr_en, s_wr_zero,
                   s_wr_addr, s_t, s_k};

   // ---------------- DELAY=4 instance, otherwise small params
   logic q_start;
   logic q_busy, q_done, q_addr_en, q_acc, q_clr, q_wr_en, q_wr_zero;
   logic [AW-1:0] q_idx, q_wr_addr, q_t, q_k;
   logic o_rst;

   lstm_fwd_ctrl #(.ADDR_WIDTH(AW), .TIMESTEP(2), .NUM_CELL(2), .NUM_INPUT(3), .DELAY(4)) u_d4 (
      .clk(clk), .rst(o_rst), .i_start(q_start), .i_hold(1'b0),
      .o_busy(q_busy), .o_done(q_done), .o_addr_en(q_addr_en), .o_acc_en(q_acc),
      .o_clr_acc(q_clr), .o_mac_idx(q_idx), .o_wr_en(q_wr_en), .o_wr_zero(q_wr_zero),
      .o_wr_addr(q_wr_addr), .o_t(q_t), .o_k(q_k));

   // ---------------- default-parameter instance
   logic f_start;
   logic f_busy, f_done, f_addr_en, f_acc, f_clr, f_wr_en, f_wr_zero;
   logic [AW-1:0] f_idx, f_wr_addr, f_t, f_k;

   lstm_fwd_ctrl #(.ADDR_WIDTH(AW), .TIMESTEP(7), .NUM_CELL(8), .NUM_INPUT(53), .DELAY(3)) u_def (
      .clk(clk), .rst(o_rst), .i_start(f_start), .i_hold(1'b0),
      .o_busy(f_busy), .o_done(f_done), .o_addr_en(f_addr_en), .o_acc_en(f_acc),
      .o_clr_acc(f_clr), .o_mac_idx(f_idx), .o_wr_en(f_wr_en), .o_wr_zero(f_wr_zero),
      .o_wr_addr(f_wr_addr), .o_t(f_t), .o_k(f_k));

   // ---------------- scoreboard and monitors (sampled on the falling edge)
   logic [12:0] exp_q[$];
   int s_acc_cnt = 0, s_acc_cell = 0, s_clr_cnt = 0, s_done_cnt = 0, s_done_cyc = 0, s_last_acc = 0;
   int q_acc_cell = 0, q_done_cnt = 0, q_done_cyc = 0, q_last_acc = 0;
   int f_acc_cnt = 0, f_wr_cnt = 0, f_done_cnt = 0, f_done_cyc = 0;
   logic [AW-1:0] f_last_addr = '0;

   always @(negedge clk) begin
      logic [12:0] e;
      if (s_acc) begin
         s_acc_cnt++;
         s_acc_cell++;
         s_last_acc = cyc;
      end
      if (s_clr) s_clr_cnt++;
      if (s_done) begin
         s_done_cnt++;
         s_done_cyc = cyc;
      end
      if (s_wr_en) begin
         e = (exp_q.size() != 0) ? exp_q.pop_front() : 13'h1fff;
         chk("s_write", {s_wr_zero, s_wr_addr}, e);
         if (!s_wr_zero) begin
            chk("s_acc_per_cell", s_acc_cell, 6);
            chk("s_drain_gap", cyc - s_last_acc, 2);
            s_acc_cell = 0;
         end
      end
   end

   always @(negedge clk) begin
      if (q_acc) begin
         q_acc_cell++;
         q_last_acc = cyc;
      end
      if (q_done) begin
         q_done_cnt++;
         q_done_cyc = cyc;
      end
      if (q_wr_en && !q_wr_zero) begin
         chk("d4_acc_per_cell", q_acc_cell, 6);
         chk("d4_drain_gap", cyc - q_last_acc, 5);
         q_acc_cell = 0;
      end
   end

   always @(negedge clk) begin
      if (f_acc) f_acc_cnt++;
      if (f_wr_en && !f_wr_zero) begin
         f_wr_cnt++;
         f_last_addr = f_wr_addr;
      end
      if (f_done) begin
         f_done_cnt++;
         f_done_cyc = cyc;
      end
   end

   // ---------------- helpers
   task automatic push_writes(input int n_data);
      for (int unsigned a = 0; a < 2; a++) exp_q.push_back({1'b1, 12'(a)});
      for (int unsigned a = 2; a < 2 + n_data; a++) exp_q.push_back({1'b0, 12'(a)});
   endtask

   task automatic start_small(output int st);
      @(posedge clk); #1;
      s_start = 1'b1;
      @(posedge clk); #1;
      st = cyc;
      s_start = 1'b0;
   endtask

   task automatic wait_small_done(input int prev, input int bound);
      for (int i = 0; i < bound; i++) begin
         if (s_done_cnt != prev) break;
         @(posedge clk); #1;
      end
      chk("s_done_seen", s_done_cnt, prev + 1);
   endtask

   int st, st_f, st2, pd;
   bit found;

   initial begin
      s_rst = 1'b0; o_rst = 1'b0;
      s_start = 1'b0; s_hold = 1'b0; q_start = 1'b0; f_start = 1'b0;
      #3;
      chk("reset_outputs_small", s_all, 0);
      chk("reset_busy_def", {f_busy, f_done, f_wr_en, f_acc, f_wr_addr}, 0);
      @(posedge clk); #1;
      s_rst = 1'b1; o_rst = 1'b1;
      @(posedge clk); #1;

      // Run 1: all three instances start together, no hold.
      push_writes(4);
      s_clr_cnt = 0; s_acc_cnt = 0;
      s_start = 1'b1; q_start = 1'b1; f_start = 1'b1;
      @(posedge clk); #1;
      st = cyc; st_f = cyc;
      s_start = 1'b0; q_start = 1'b0; f_start = 1'b0;
      chk("zero_state_after_start", {s_busy, s_wr_en, s_wr_zero}, 3'b111);
      pd = s_done_cnt;
      wait_small_done(pd, 100);
      chk("s_latency", s_done_cyc - st, 34);
      chk("s_clr_count", s_clr_cnt, 4);
      chk("s_acc_count", s_acc_cnt, 24);
      chk("s_sb_empty", exp_q.size(), 0);
      @(posedge clk); #1;
      chk("s_done_one_cycle", {s_done, s_busy}, 0);
      chk("s_done_count", s_done_cnt, pd + 1);
      for (int i = 0; i < 50; i++) begin
         if (q_done_cnt != 0) break;
         @(posedge clk); #1;
      end
      chk("d4_latency", q_done_cyc - st, 46);

      // Run 2: 5-cycle hold at MAC j=2, t=1, k=1.
      push_writes(4);
      s_clr_cnt = 0;
      start_small(st);
      found = 1'b0;
      for (int i = 0; i < 100; i++) begin
         if (s_acc && s_idx == 2 && s_t == 1 && s_k == 1) begin
            found = 1'b1;
            break;
         end
         @(posedge clk); #1;
      end
      chk("hold_point_reached", found, 1);
      s_hold = 1'b1;
      for (int i = 0; i < 5; i++) begin
         #2;
         chk("hold_strobes", {s_acc, s_addr_en, s_clr, s_wr_en}, 0);
         chk("hold_mac_idx", s_idx, 2);
         @(posedge clk); #1;
      end
      s_hold = 1'b0;
      #1;
      chk("hold_reissue", {s_acc, s_idx}, {1'b1, 12'd2});
      pd = s_done_cnt;
      wait_small_done(pd, 100);
      chk("hold_latency", s_done_cyc - st, 39);
      chk("hold_clr_count", s_clr_cnt, 4);
      chk("hold_sb_empty", exp_q.size(), 0);

      // Run 3: start re-asserted while busy and held through DONE.
      push_writes(4);
      push_writes(4);
      start_small(st);
      repeat (10) @(posedge clk);
      #1;
      s_start = 1'b1;
      pd = s_done_cnt;
      wait_small_done(pd, 100);
      chk("restart_ignored_latency", s_done_cyc - st, 34);
      chk("restart_idle_gap", s_busy, 0);
      @(posedge clk); #1;
      st2 = cyc;
      s_start = 1'b0;
      chk("restart_second_run", {s_busy, s_wr_zero}, 2'b11);
      pd = s_done_cnt;
      wait_small_done(pd, 100);
      chk("restart_second_latency", s_done_cyc - st2, 34);
      chk("restart_sb_empty", exp_q.size(), 0);

      // Run 4: reset during WRITE t=1, k=0, then a clean full run.
      push_writes(2);
      start_small(st);
      found = 1'b0;
      for (int i = 0; i < 100; i++) begin
         if (s_wr_en && !s_wr_zero && s_t == 1 && s_k == 0) begin
            found = 1'b1;
            break;
         end
         @(posedge clk); #1;
      end
      chk("reset_point_reached", found, 1);
      pd = s_done_cnt;
      s_rst = 1'b0;
      #1;
      chk("async_reset_outputs", s_all, 0);
      repeat (3) @(posedge clk);
      #1;
      chk("reset_no_done", s_done_cnt, pd);
      chk("reset_sb_empty", exp_q.size(), 0);
      s_rst = 1'b1;
      s_acc_cell = 0;
      @(posedge clk); #1;
      push_writes(4);
      s_clr_cnt = 0;
      start_small(st);
      pd = s_done_cnt;
      wait_small_done(pd, 100);
      chk("post_reset_latency", s_done_cyc - st, 34);
      chk("post_reset_clr_count", s_clr_cnt, 4);
      chk("post_reset_sb_empty", exp_q.size(), 0);

      // Default instance totals.
      for (int i = 0; i < 4000; i++) begin
         if (f_done_cnt != 0) break;
         @(posedge clk); #1;
      end
      chk("def_done_seen", f_done_cnt, 1);
      chk("def_latency", f_done_cyc - st_f, 3704);
      chk("def_data_writes", f_wr_cnt, 56);
      chk("def_last_addr", f_last_addr, 63);
      chk("def_acc_count", f_acc_cnt, 3472);
      @(posedge clk); #1;
      chk("def_idle_after", f_busy, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/lstm_fwd_ctrl.md
Name: lstm_fwd_ctrl

Overview:
Sequencer for the LSTM forward-propagation datapath. It steps over timesteps, then cells, then the MAC index. It drives the H/C read-address generator enable, the gate accumulators, the activation-drain wait and the H/C write-back. Before timestep 0 it zero-fills the t=-1 slot of H/C memory. It sits between the top-level layer controller (start/done handshake) and the forward datapath.

Parameters:
ADDR_WIDTH, 12, width of all counters and address outputs
TIMESTEP, 7, timesteps per sequence
NUM_CELL, 8, LSTM cells per layer
NUM_INPUT, 53, input features per timestep
DELAY, 3, cycles from last MAC to valid activated h/c (must be >=1)
MAC_LEN (local), NUM_INPUT+NUM_CELL+1, accumulate cycles per cell (inputs, recurrent h, bias)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset (0 = reset)
i_start  in  1  start request, sampled only in IDLE
i_hold  in  1  stall from memory/datapath; freezes sequencing
o_busy  out  1  high in every state except IDLE
o_done  out  1  one-cycle pulse at end of sequence
o_addr_en  out  1  enable to H/C read-address generator
o_acc_en  out  1  accumulate strobe to gate MACs
o_clr_acc  out  1  load (not add) the first product of a cell
o_mac_idx  out  ADDR_WIDTH  current MAC index j, 0..MAC_LEN-1
o_wr_en  out  1  H/C write strobe
o_wr_zero  out  1  write-data select: zeros (t=-1 fill)
o_wr_addr  out  ADDR_WIDTH  H/C write address
o_t  out  ADDR_WIDTH  current timestep
o_k  out  ADDR_WIDTH  current cell

Behaviour:
- States: IDLE, ZERO, MAC, DRAIN, WRITE, DONE. Counters: j (MAC), d (drain), k (cell), t (timestep), z (zero-fill).
- Reset (rst=0, async): state=IDLE, all counters 0, all outputs 0.
- IDLE: i_start=1 -> ZERO, z=0. i_start is ignored in all other states.
- ZERO: o_wr_en=1, o_wr_zero=1, o_wr_addr=z. z counts 0..NUM_CELL-1. After z=NUM_CELL-1 -> MAC with t=k=j=0.
- MAC: o_addr_en=1, o_acc_en=1, o_mac_idx=j, o_clr_acc=1 only when j=0. j counts 0..MAC_LEN-1. After j=MAC_LEN-1 -> DRAIN, d=0.
- DRAIN: all strobes 0 for DELAY cycles (d=0..DELAY-1), then -> WRITE.
- WRITE: one cycle, o_wr_en=1, o_wr_zero=0, o_wr_addr=(t+1)*NUM_CELL+k. Next state:
  - k<NUM_CELL-1: k+1, j=0, -> MAC.
  - else if t<TIMESTEP-1: k=0, t+1, -> MAC.
  - else: -> DONE.
- DONE: o_done=1 and o_busy=1 for one cycle, then -> IDLE. Counters are cleared on entry to IDLE.
- Write address range: 0..NUM_CELL*(TIMESTEP+1)-1. The highest address is written in the final WRITE.
- Address arithmetic is performed in ADDR_WIDTH, unsigned. Parameters guarantee no overflow; no wrap handling.
- i_hold=1 in ZERO/MAC/DRAIN/WRITE:
  - state and all counters hold;
  - o_addr_en, o_acc_en, o_clr_acc and o_wr_en are forced 0 combinationally;
  - o_mac_idx, o_wr_addr, o_t and o_k keep showing held values.
  - On release, the held cycle's strobes re-issue, so no beat is lost or duplicated.
  - i_hold is ignored in IDLE and DONE.
- All other outputs decode from registered state and counters. There is no other combinational input-to-output path.
- Total latency, measured from the edge sampling i_start to the edge entering DONE: NUM_CELL + TIMESTEP*NUM_CELL*(MAC_LEN+DELAY+1) cycles with no hold. Defaults give 8+3696=3704.
- Reset asserted mid-operation: immediate return to IDLE, outputs 0. No partial done pulse.

Decomposition:
- Shared header/package lstm_pkg holds:
  - state encodings (IDLE..DONE);
  - the MAC_LEN derivation;
  - the H/C slot-address formula, shared with the read-address generator so the two agree on the t=-1 offset.
- One natural sub-module, cnt_tc: a parameterised up-counter with enable, sync clear and terminal-count flag. Instantiate it for j, d, k, t and z.

Test Plan:
- Small params (TIMESTEP=2, NUM_CELL=2, NUM_INPUT=3, DELAY=1, so MAC_LEN=6), start pulse, no hold:
  - o_wr_zero writes at addr 0,1;
  - o_clr_acc exactly 4 times;
  - data writes at addr 2,3,4,5;
  - o_done one cycle, 34 edges after start sampled;
  - o_busy low afterwards.
- Defaults, single start: 3704 edges to DONE; 56 data writes; last o_wr_addr=63; o_acc_en high 3472 cycles.
- i_hold for 5 cycles at MAC j=2, t=1, k=1:
  - strobes 0 during hold; o_mac_idx stays 2;
  - completion delayed by exactly 5 cycles;
  - accumulate count per cell unchanged (6, small params).
- i_start re-pulsed while busy and held high through DONE: ignored while busy; a second run starts only when sampled in IDLE.
- rst=0 during WRITE at t=1, k=0: all outputs 0 asynchronously, no o_done; the next start produces a full, correct sequence.
- DELAY=1 vs DELAY=4, small params: cycles between last o_acc_en and o_wr_en equal DELAY+1.
